div_4bits: RTL and testbench
============================

# div_4bits

Sequential 4-bit unsigned restoring divider: the inverse-operation companion to the team's 4-bit adder (`adder_4bits`). It accepts a dividend and divisor on a start pulse and runs one subtract/restore step per clock. It returns quotient and remainder with a done pulse. It sits beside the adder in the arithmetic lab datapath and is driven by the same kind of directed stimulus bench.

## Interface
- No parameters; width fixed at 4 bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  4  dividend, unsigned, captured on the accepted start edge.
- `b`  in  4  divisor, unsigned, captured on the accepted start edge.
- `q`  out  4  quotient, registered.
- `r`  out  4  remainder, registered.
- `busy`  out  1  high while in CALC.
- `done`  out  1  one-cycle pulse; `q`/`r`/`dz` valid from this cycle on.
- `dz`  out  1  divide-by-zero flag for the last completed operation.

## Operation
- Reset values: `q`=0, `r`=0, `busy`=0, `done`=0, `dz`=0. Reset puts the FSM in IDLE, clears the internal dividend, divisor, partial remainder and step counter.
- FSM states:
  - **IDLE**
    - `start`=1 with `b`≠0 → CALC. Capture `a`,`b`; partial remainder = 0; counter = 0; `busy`=1.
    - `start`=1 with `b`=0 → stay in IDLE. Set `q`=4'hF, `r`=`a`, `dz`=1, `done`=1 for one cycle.
    - `start`=0 → stay in IDLE; outputs hold.
  - **CALC**, one step per edge, MSB of dividend first:
    - p[4:0] = {rem[3:0], dvd[3]}; shift dvd left by one.
    - If p ≥ {1'b0,b}: rem = p − b, and shift quotient bit 1 into the quotient register.
    - Otherwise: rem = p[3:0], and shift in 0.
    - The 5-bit compare is required so that no overflow is lost.
    - On the step with counter = 3: load `q` and `r` from the final values, `dz`=0, `done`=1, `busy`=0 → IDLE.
- `start` while `busy` is ignored and has no effect on the operation in flight.
- `q`, `r` and `dz` hold their values until the next completion. They do not change while CALC is in progress.
- `start` held high continuously: a new operation is accepted on the first IDLE edge after `done`. Back-to-back operations therefore occur every 5 cycles.

## Timing
- Accepted start at edge N (b≠0):
  - `busy` is high after edges N … N+3.
  - `done`, `q` and `r` update after edge N+4. Latency is 4 cycles from acceptance.
  - `done` falls after edge N+5 unless another zero-divisor start produces a new pulse.
- Divide by zero: `done` and `dz` go high after edge N+1? No: they update at edge N itself, giving 1-cycle latency. `busy` never rises.
- Asynchronous reset mid-CALC: all outputs return to reset values immediately. The in-flight result is discarded and no `done` is produced.
- Reset release: the first start can be accepted on the first rising edge with `rst_n`=1.
- Invariant on every non-dz completion: `a` = `q`·`b` + `r`, with `r` < `b`.

## Test plan
- a=7, b=2, start pulsed 1 cycle → `busy` high 4 cycles; `done` at N+4 with `q`=3, `r`=1, `dz`=0.
- a=15, b=1 → `q`=15, `r`=0. Then a=3, b=5 → `q`=0, `r`=3. Then a=15, b=15 → `q`=1, `r`=0.
- a=9, b=0 → `done` and `dz`=1 after the accepting edge; `q`=4'hF, `r`=9; `busy` stays 0.
- a=12, b=5 started, then `start` re-asserted with a=1, b=1 at N+2 → ignored; result is `q`=2, `r`=2.
- a=14, b=3 started, `rst_n` pulled low at N+2 → outputs 0 immediately, no `done`. After release, a=14, b=3 → `q`=4, `r`=2.
- Exhaustive sweep of all 256 a/b pairs with `start` held high → every `done` matches the reference a/b and a%b (or the dz values when b=0), with a 5-cycle period for b≠0.

Source files
------------

// File: rtl/div_4bits.sv
// div_4bits: sequential 4-bit unsigned restoring divider, one subtract/restore step per clock.
// A zero divisor completes immediately with q=4'hF, r=a and the dz flag set.
module div_4bits (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] q,
    output logic [3:0] r,
    output logic       busy,
    output logic       done,
    output logic       dz
);
    typedef enum logic {IDLE, CALC} state_t;

    state_t     state_q, state_d;
    logic [3:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d;
    logic [3:0] q_q, q_d, r_q, r_d;
    logic [1:0] cnt_q, cnt_d;
    logic       done_q, done_d, dz_q, dz_d;
    logic [4:0] p, diff;
    logic       ge;
    logic [3:0] rem_nx, quo_nx;

    // Five-bit trial subtraction so a partial remainder with its top bit shifted out is not lost
    assign p      = {rem_q, dvd_q[3]};
    assign diff   = p - {1'b0, dvs_q};
    assign ge     = p >= {1'b0, dvs_q};
    assign rem_nx = ge ? diff[3:0] : p[3:0];
    assign quo_nx = {quo_q[2:0], ge};

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start && b != 4'd0) begin
                state_d = CALC;
                dvd_d   = a;
                dvs_d   = b;
                rem_d   = 4'd0;
                quo_d   = 4'd0;
                cnt_d   = 2'd0;
            end else if (start) begin
                q_d    = 4'hF;
                r_d    = a;
                dz_d   = 1'b1;
                done_d = 1'b1;
            end
        end else begin
            dvd_d = {dvd_q[2:0], 1'b0};
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                state_d = IDLE;
                q_d     = quo_nx;
                r_d     = rem_nx;
                dz_d    = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= 4'd0;
            dvs_q   <= 4'd0;
            rem_q   <= 4'd0;
            quo_q   <= 4'd0;
            cnt_q   <= 2'd0;
            q_q     <= 4'd0;
            r_q     <= 4'd0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign q    = q_q;
    assign r    = r_q;
    assign busy = state_q == CALC;
    assign done = done_q;
    assign dz   = dz_q;
endmodule

// File: tb/tb_div_4bits.sv
// tb_div_4bits: table-driven, randomized and exhaustive checks of div_4bits against a quotient/remainder model.
module tb_div_4bits;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = 4'd0, b = 4'd0;
    logic [3:0] q, r;
    logic       busy, done, dz;
    int checks = 0, errors = 0;

    typedef struct {
        logic [3:0] a, b, eq, er;
        logic       edz;
    } vec_t;

    div_4bits dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .q(q), .r(r), .busy(busy), .done(done), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: plain integer division, or the fixed zero-divisor result
    task automatic model(input int ta, input int tb, output logic [3:0] eq, output logic [3:0] er, output logic edz);
        eq  = tb == 0 ? 4'hF : 4'(ta / tb);
        er  = tb == 0 ? 4'(ta) : 4'(ta % tb);
        edz = tb == 0;
    endtask

    // Called on a negedge with the DUT idle; returns on the negedge where done is seen
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb, input bit hold,
                         input logic [3:0] eq, input logic [3:0] er, input logic edz);
        int k = 0, nb = 0;
        string t = $sformatf("op %0d/%0d", ta, tb);
        a = ta;
        b = tb;
        start = 1'b1;
        do begin
            @(negedge clk);
            k++;
            if (!hold) start = 1'b0;
            if (busy) nb++;
        end while (!done && k < 12);
        chk({t, " done"}, int'(done), 1);
        chk({t, " latency"}, k, tb == 0 ? 1 : 5);
        chk({t, " busy cycles"}, nb, tb == 0 ? 0 : 4);
        chk({t, " q"}, int'(q), int'(eq));
        chk({t, " r"}, int'(r), int'(er));
        chk({t, " dz"}, int'(dz), int'(edz));
    endtask

    initial begin
        vec_t vecs[$];
        logic [3:0] eq, er, hq;
        logic edz;
        vecs = '{
            '{4'd7,  4'd2,  4'd3,  4'd1,  1'b0},
            '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0},
            '{4'd3,  4'd5,  4'd0,  4'd3,  1'b0},
            '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0},
            '{4'd9,  4'd0,  4'd15, 4'd9,  1'b1},
            '{4'd0,  4'd7,  4'd0,  4'd0,  1'b0},
            '{4'd8,  4'd3,  4'd2,  4'd2,  1'b0},
            '{4'd15, 4'd0,  4'd15, 4'd15, 1'b1},
            '{4'd13, 4'd8,  4'd1,  4'd5,  1'b0}
        };
        repeat (2) @(negedge clk);
        chk("reset q", int'(q), 0);
        chk("reset r", int'(r), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset dz", int'(dz), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, 1'b0, vecs[i].eq, vecs[i].er, vecs[i].edz);
            @(negedge clk);
            chk("done one-cycle pulse", int'(done), 0);
            chk("result holds after done", int'(q), int'(vecs[i].eq));
        end

        // Start while busy is ignored and results hold during CALC
        hq = q;
        a = 4'd12;
        b = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd1;
        b = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("q holds during calc", int'(q), int'(hq));
        chk("busy mid calc", int'(busy), 1);
        repeat (2) @(negedge clk);
        chk("ignore start done", int'(done), 1);
        chk("ignore start q", int'(q), 2);
        chk("ignore start r", int'(r), 2);
        @(negedge clk);

        // Async reset mid-CALC discards the operation
        a = 4'd14;
        b = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset q", int'(q), 0);
        chk("async reset r", int'(r), 0);
        chk("async reset busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no done after reset", int'(done), 0);
        end
        do_op(4'd14, 4'd3, 1'b0, 4'd4, 4'd2, 1'b0);
        @(negedge clk);

        // Random operations
        repeat (40) begin
            logic [3:0] ra, rb;
            ra = 4'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            model(ra, rb, eq, er, edz);
            do_op(ra, rb, 1'b0, eq, er, edz);
            @(negedge clk);
        end

        // Exhaustive sweep with start held high, back-to-back
        for (int i = 0; i < 256; i++) begin
            model(i / 16, i % 16, eq, er, edz);
            do_op(4'(i / 16), 4'(i % 16), 1'b1, eq, er, edz);
        end
        start = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
